// File: rtl/craft_key_register.sv
// CRAFT nibble-serial tweakey register.
// Loads TK(r mod 4) on CK0, then rotates one nibble per clock.
module craft_key_register (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [127:0] key,
  input  logic [63:0]  tweak,
  input  logic [7:0]   r,
  input  logic         CK0,
  output logic [3:0]   out
);

  logic [63:0] w_k0;
  logic [63:0] w_k1;
  logic [63:0] w_tq;
  logic [63:0] w_tk;
  logic [63:0] r_tk;

  assign w_k0 = key[127:64];
  assign w_k1 = key[63:0];

  // Q(T): nibble i of the result is nibble Q[i] of T
  assign w_tq = {
    tweak[15:12], tweak[23:20],
    tweak[3:0],   tweak[43:40],
    tweak[7:4],   tweak[31:28],
    tweak[27:24], tweak[55:52],
    tweak[19:16], tweak[51:48],
    tweak[35:32], tweak[47:44],
    tweak[39:36], tweak[63:60],
    tweak[59:56], tweak[11:8]
  };

  always_comb begin
    w_tk = '0;
    unique case (r[1:0])
      2'd0: w_tk = w_k0 ^ tweak;
      2'd1: w_tk = w_k1 ^ tweak;
      2'd2: w_tk = w_k0 ^ w_tq;
      2'd3: w_tk = w_k1 ^ w_tq;
      default: w_tk = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tk <= '0;
    end else if (en) begin
      if (CK0) begin
        r_tk <= w_tk;
      end else begin
        r_tk <= {r_tk[59:0], r_tk[63:60]};
      end
    end
  end

  assign out = r_tk[63:60];

endmodule

// File: tb/tb_craft_key_register.sv
// Self-checking bench for craft_key_register.
// Table vectors, corner sequences and a random run against a model.
module tb_craft_key_register;

  logic         clk;
  logic         reset_n;
  logic         en;
  logic [127:0] key;
  logic [63:0]  tweak;
  logic [7:0]   r;
  logic         CK0;
  logic [3:0]   out;

  int checks;
  int errors;

  logic [63:0] m_word;
  int          m_k;

  localparam logic [127:0] KEY0 =
    128'h27a6781a43f364bc916708d5fbb5aefe;
  localparam logic [63:0] TW0 = 64'h54cd94ffd0670a58;
  localparam logic [63:0] TK0 = 64'h736bece593946ee4;
  localparam logic [63:0] TK1 = 64'hc5aa9c2a2bd2a4a6;
  localparam logic [63:0] TK2 = 64'h212225163e0a91f6;
  localparam logic [63:0] TK3 = 64'h97e355d9864c5bb4;

  typedef struct {
    logic [7:0]  rr;
    logic [63:0] tk;
  } vec_t;

  vec_t vecs [6];

  craft_key_register dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .key     (key),
    .tweak   (tweak),
    .r       (r),
    .CK0     (CK0),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] nib(
    input logic [63:0] x, input int i);
    return x[63-4*i -: 4];
  endfunction

  function automatic logic [63:0] tk_of(
    input logic [127:0] k,
    input logic [63:0]  t,
    input logic [7:0]   rr);
    int          q [16] = '{12,10,15,5,14,8,9,2,
                            11,3,7,4,6,0,1,13};
    logic [63:0] qt;
    logic [63:0] half;
    qt = '0;
    for (int i = 0; i < 16; i++)
      qt[63-4*i -: 4] = nib(t, q[i]);
    half = rr[0] ? k[63:0] : k[127:64];
    return rr[1] ? (half ^ qt) : (half ^ t);
  endfunction

  task automatic chk(input string name,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: out=%h expected=%h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic step(input logic e,
                      input logic c,
                      input logic [7:0] rr);
    en  = e;
    CK0 = c;
    r   = rr;
    @(posedge clk);
    if (e) begin
      if (c) begin
        m_word = tk_of(key, tweak, rr);
        m_k    = 0;
      end else begin
        m_k = (m_k + 1) % 16;
      end
    end
    #1;
    chk("model", out, nib(m_word, m_k));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    m_word  = '0;
    m_k     = 0;
    reset_n = 1'b0;
    en      = 1'b0;
    CK0     = 1'b0;
    r       = '0;
    key     = KEY0;
    tweak   = TW0;

    vecs[0] = '{8'h00, TK0};
    vecs[1] = '{8'h01, TK1};
    vecs[2] = '{8'h02, TK2};
    vecs[3] = '{8'h03, TK3};
    vecs[4] = '{8'h04, TK0};
    vecs[5] = '{8'hFE, TK2};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", out, 4'h0);
    reset_n = 1'b1;

    // round streams with wrap on the 17th cycle
    for (int v = 0; v < 6; v++) begin
      step(1'b1, 1'b1, vecs[v].rr);
      chk("tbl_load", out, nib(vecs[v].tk, 0));
      for (int j = 1; j <= 16; j++) begin
        step(1'b1, 1'b0, 8'($urandom));
        chk("tbl_stream", out, nib(vecs[v].tk, j % 16));
      end
    end

    // enable low freezes, even with CK0
    step(1'b1, 1'b1, 8'h00);
    repeat (3) step(1'b1, 1'b0, 8'h00);
    chk("pre_freeze", out, nib(TK0, 3));
    for (int j = 0; j < 17; j++) begin
      step(1'b0, 1'b1, 8'h04);
      chk("frozen", out, nib(TK0, 3));
    end
    step(1'b1, 1'b0, 8'h04);
    chk("resume", out, nib(TK0, 4));

    // CK0 held high keeps reloading
    for (int j = 0; j < 3; j++) begin
      step(1'b1, 1'b1, 8'h01);
      chk("ck0_hold", out, nib(TK1, 0));
    end

    // key change mid-round is invisible
    key = {$urandom, $urandom, $urandom, $urandom};
    for (int j = 1; j < 16; j++) begin
      step(1'b1, 1'b0, 8'($urandom));
      chk("key_change", out, nib(TK1, j));
    end
    key = KEY0;

    // async reset mid-stream
    step(1'b1, 1'b1, 8'h03);
    step(1'b1, 1'b0, 8'h03);
    reset_n = 1'b0;
    m_word  = '0;
    m_k     = 0;
    #2;
    chk("async_reset", out, 4'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step(1'b1, 1'b0, 8'h02);
      chk("post_reset", out, 4'h0);
    end
    step(1'b1, 1'b1, 8'h03);
    chk("reload", out, nib(TK3, 0));

    // random traffic against the model
    for (int j = 0; j < 400; j++) begin
      if ($urandom_range(0, 19) == 0)
        key = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 29) == 0)
        tweak = {$urandom, $urandom};
      step(($urandom_range(0, 4) != 0),
           ($urandom_range(0, 7) == 0),
           8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
